// File: rtl/keypad_scan.sv
// 4x4 matrix-keypad scanner: walks a low column strobe, synchronizes the rows,
// rejects multi-key scans and debounces full-scan results onto keystat/keypress.
module keypad_scan #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEBOUNCE = 5
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       R3,
  input  logic       R2,
  input  logic       R1,
  input  logic       R0,
  output logic [3:0] COL,
  output logic [4:0] keystat,
  output logic       keypress
);

  localparam int unsigned      DIV_W    = $clog2(SCAN_DIV);
  localparam int unsigned      DB_W     = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE);
  localparam logic [4:0]       KEY_IDLE = 5'h10;

  typedef enum logic [1:0] {HIT_NONE, HIT_ONE, HIT_MULTI} hit_e;

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       rowsync_q, rowsync_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  hit_e             hit_q, hit_d;
  logic [4:0]       code_q, code_d;
  logic [4:0]       cand_q, cand_d;
  logic [DB_W-1:0]  stable_q, stable_d;
  logic [4:0]       keystat_q, keystat_d;
  logic             keypress_q, keypress_d;

  hit_e       scan_hit;
  logic [4:0] scan_code;
  logic [4:0] scan_result;
  logic       scan_end;

  function automatic logic [4:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [4:0] code;
    code = KEY_IDLE;
    case ({row, col})
      4'h0: code = 5'h01;
      4'h1: code = 5'h02;
      4'h2: code = 5'h03;
      4'h3: code = 5'h0A;
      4'h4: code = 5'h04;
      4'h5: code = 5'h05;
      4'h6: code = 5'h06;
      4'h7: code = 5'h0B;
      4'h8: code = 5'h07;
      4'h9: code = 5'h08;
      4'hA: code = 5'h09;
      4'hB: code = 5'h0C;
      4'hC: code = 5'h0E;
      4'hD: code = 5'h00;
      4'hE: code = 5'h0F;
      4'hF: code = 5'h0D;
      default: code = KEY_IDLE;
    endcase
    return code;
  endfunction

  always_comb begin
    sync1_d     = {R3, R2, R1, R0};
    rowsync_d   = sync1_q;
    div_d       = div_q;
    col_d       = col_q;
    hit_d       = hit_q;
    code_d      = code_q;
    cand_d      = cand_q;
    stable_d    = stable_q;
    keystat_d   = keystat_q;
    scan_hit    = hit_q;
    scan_code   = code_q;
    scan_result = KEY_IDLE;
    scan_end    = 1'b0;

    if (div_q == DIV_LAST) begin
      div_d = '0;
      col_d = col_q + 2'd1;
      for (int unsigned r = 0; r < 4; r++) begin
        if (!rowsync_q[r]) begin
          scan_code = key_code(2'(r), col_q);
          scan_hit  = (scan_hit == HIT_NONE) ? HIT_ONE : HIT_MULTI;
        end
      end
      // Column 3 closes the scan: its hits are judged now and the tally restarts.
      if (col_q == 2'd3) begin
        scan_end = 1'b1;
        hit_d    = HIT_NONE;
        code_d   = KEY_IDLE;
      end else begin
        hit_d  = scan_hit;
        code_d = scan_code;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (scan_end && scan_hit != HIT_MULTI) begin
      scan_result = (scan_hit == HIT_ONE) ? scan_code : KEY_IDLE;
      if (scan_result == cand_q) begin
        if (stable_q != DB_MAX) stable_d = stable_q + DB_W'(1);
      end else begin
        cand_d   = scan_result;
        stable_d = DB_W'(1);
      end
    end

    if (stable_q == DB_MAX && cand_q != keystat_q) keystat_d = cand_q;
    keypress_d = (keystat_d != KEY_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q    <= '1;
      rowsync_q  <= '1;
      div_q      <= '0;
      col_q      <= '0;
      hit_q      <= HIT_NONE;
      code_q     <= KEY_IDLE;
      cand_q     <= KEY_IDLE;
      stable_q   <= '0;
      keystat_q  <= KEY_IDLE;
      keypress_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      rowsync_q  <= rowsync_d;
      div_q      <= div_d;
      col_q      <= col_d;
      hit_q      <= hit_d;
      code_q     <= code_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      keystat_q  <= keystat_d;
      keypress_q <= keypress_d;
    end
  end

  assign COL      = ~(4'b0001 << col_q);
  assign keystat  = keystat_q;
  assign keypress = keypress_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad model answers the column strobe; a scan-level
// reference of the debounce rules and a table of directed vectors check keystat.
module tb_keypad_scan;

  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned DEBOUNCE  = 3;
  localparam int unsigned SCAN_CLKS = 16;
  localparam int unsigned NVEC      = 18;
  localparam logic [4:0]  IDLE      = 5'h10;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       R3, R2, R1, R0;
  logic [3:0] COL;
  logic [4:0] keystat;
  logic       keypress;

  logic [15:0] pressed = '0;   // bit r*4+c set = key (row r, column c) held
  logic [3:0]  rows;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic        mon_en = 1'b0;
  logic [4:0]  last_ks = IDLE;
  logic [4:0]  hist[$];
  logic [4:0]  exp_hist[$];
  logic [4:0]  ks_obs;

  logic [4:0]  key_code [16];
  logic [4:0]  m_cand, m_ks;
  int unsigned m_stable;

  typedef struct {
    logic [15:0] mask;
    int unsigned scans;
    logic [4:0]  exp_ks;
  } vec_t;
  vec_t tbl [NVEC];

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .R3(R3), .R2(R2), .R1(R1), .R0(R0),
    .COL(COL), .keystat(keystat), .keypress(keypress)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !COL[c]) rows[r] = 1'b0;
  end
  assign {R3, R2, R1, R0} = rows;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (keystat !== last_ks) begin
        hist.push_back(keystat);
        last_ks = keystat;
      end
      check("keypress_vs_keystat", 32'(keypress), 32'(keystat != IDLE));
      check("col_one_low", $countones(~COL), 1);
    end
  end

  // Scan-level reference: one result per full scan, then the debounce rules.
  task automatic model_reset();
    m_cand   = IDLE;
    m_stable = 0;
    m_ks     = IDLE;
  endtask

  task automatic model_scan(input logic [15:0] mask);
    int unsigned n;
    logic [4:0]  res;
    n   = $countones(mask);
    res = IDLE;
    if (n == 1)
      for (int k = 0; k < 16; k++) if (mask[k]) res = key_code[k];
    if (n < 2) begin
      if (res == m_cand) begin
        if (m_stable < DEBOUNCE) m_stable++;
      end else begin
        m_cand   = res;
        m_stable = 1;
      end
    end
    if (m_stable == DEBOUNCE && m_cand != m_ks) m_ks = m_cand;
  endtask

  // One scan-aligned slot: keys held for a whole scan; keystat is observed
  // two clocks in, where it reflects every scan before this one.
  task automatic run_scan(input logic [15:0] mask);
    pressed = mask;
    repeat (2) @(negedge CLK);
    ks_obs = keystat;
    check("scan_vs_model", ks_obs, m_ks);
    repeat (SCAN_CLKS - 2) @(negedge CLK);
    model_scan(mask);
  endtask

  task automatic check_hist(input string name);
    int unsigned n;
    check({name, "_len"}, hist.size(), exp_hist.size());
    n = (hist.size() < exp_hist.size()) ? hist.size() : exp_hist.size();
    for (int unsigned i = 0; i < n; i++)
      check($sformatf("%s_%0d", name, i), hist[i], exp_hist[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  exp_col;
    logic [4:0]  prev;
    logic [15:0] mask;
    int unsigned bad, sel, a, b, hold;

    key_code = '{5'h01, 5'h02, 5'h03, 5'h0A,
                 5'h04, 5'h05, 5'h06, 5'h0B,
                 5'h07, 5'h08, 5'h09, 5'h0C,
                 5'h0E, 5'h00, 5'h0F, 5'h0D};

    tbl[0]  = '{16'h0000, 1, 5'h10};
    tbl[1]  = '{16'h0020, 2, 5'h10};  // row1/col1 not yet debounced
    tbl[2]  = '{16'h0020, 1, 5'h05};  // third stable scan releases it
    tbl[3]  = '{16'h0020, 4, 5'h05};  // held: no repeat
    tbl[4]  = '{16'h0000, 2, 5'h05};
    tbl[5]  = '{16'h0000, 1, 5'h10};
    tbl[6]  = '{16'h0003, 5, 5'h10};  // two keys together ignored
    tbl[7]  = '{16'h0001, 3, 5'h01};
    tbl[8]  = '{16'h0002, 3, 5'h02};  // direct key-to-key change
    tbl[9]  = '{16'h0000, 5, 5'h10};
    tbl[10] = '{16'h0001, 4, 5'h01};
    tbl[11] = '{16'h0000, 5, 5'h10};
    tbl[12] = '{16'h0008, 4, 5'h0A};
    tbl[13] = '{16'h0000, 5, 5'h10};
    tbl[14] = '{16'h0002, 4, 5'h02};
    tbl[15] = '{16'h0000, 5, 5'h10};
    tbl[16] = '{16'h4000, 4, 5'h0F};
    tbl[17] = '{16'h0000, 5, 5'h10};

    // Reset, then the column walk with no key.
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_keystat", keystat, IDLE);
    check("rst_keypress", keypress, 0);
    check("rst_col", COL, 4'b1110);
    mon_en = 1'b1;
    RST_N  = 1'b1;
    model_reset();
    for (int k = 1; k <= 64; k++) begin
      @(negedge CLK);
      exp_col = 4'b1111;
      exp_col[(k / 4) % 4] = 1'b0;
      check($sformatf("col_step_%0d", k), COL, exp_col);
    end
    repeat (4) model_scan(16'h0000);
    check("idle_keystat", keystat, IDLE);

    // Directed vectors; each entry's result is observed in the next slot.
    hist.delete();
    exp_hist.delete();
    prev = IDLE;
    for (int i = 0; i < NVEC; i++)
      if (tbl[i].exp_ks != prev) begin
        exp_hist.push_back(tbl[i].exp_ks);
        prev = tbl[i].exp_ks;
      end
    for (int i = 0; i < NVEC; i++) begin
      for (int unsigned s = 0; s < tbl[i].scans; s++) begin
        run_scan(tbl[i].mask);
        if (s == 0 && i > 0) check($sformatf("vec%0d", i - 1), ks_obs, tbl[i-1].exp_ks);
      end
    end
    run_scan(16'h0000);
    check($sformatf("vec%0d", NVEC - 1), ks_obs, tbl[NVEC-1].exp_ks);
    check_hist("seq_hist");

    // Bounce on row3/col2, toggled every 10 clocks starting 4 clocks into a scan.
    hist.delete();
    exp_hist.delete();
    exp_hist.push_back(5'h0F);
    repeat (4) @(negedge CLK);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      pressed = (i % 2 == 0) ? 16'h4000 : 16'h0000;
      repeat (10) begin
        @(negedge CLK);
        if (keystat !== IDLE) bad++;
      end
    end
    check("bounce_quiet_bad_cycles", bad, 0);
    pressed = 16'h4000;
    repeat (8) @(negedge CLK);
    check("bounce_hold_early", keystat, IDLE);
    repeat (4) @(negedge CLK);
    check("bounce_hold_late", keystat, 5'h0F);
    repeat (12) @(negedge CLK);
    check_hist("bounce_hist");
    m_cand   = 5'h0F;
    m_stable = DEBOUNCE;
    m_ks     = 5'h0F;
    repeat (4) run_scan(16'h0000);

    // Reset while '+' is being debounced; it must start over.
    hist.delete();
    exp_hist.delete();
    exp_hist.push_back(5'h0A);
    exp_hist.push_back(IDLE);
    run_scan(16'h0008);
    run_scan(16'h0008);
    RST_N = 1'b0;
    #1;
    check("midrst_keystat", keystat, IDLE);
    check("midrst_col", COL, 4'b1110);
    repeat (5) @(negedge CLK);
    check("midrst_keypress", keypress, 0);
    RST_N = 1'b1;
    model_reset();
    repeat (3) run_scan(16'h0008);
    check("midrst_not_early", ks_obs, IDLE);
    run_scan(16'h0008);
    check("midrst_after_3", ks_obs, 5'h0A);
    run_scan(16'h0008);
    repeat (4) run_scan(16'h0000);
    check_hist("midrst_hist");

    // Random key patterns held for whole scans, against the reference.
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        mask = 16'h0000;
      end else if (sel < 8) begin
        mask = 16'(1) << $urandom_range(0, 15);
      end else begin
        a    = $urandom_range(0, 15);
        b    = (a + $urandom_range(1, 15)) % 16;
        mask = (16'(1) << a) | (16'(1) << b);
      end
      hold = $urandom_range(1, 5);
      repeat (hold) run_scan(mask);
    end
    repeat (4) run_scan(16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
